// File: rtl/xsim_msg_source.sv
// xsim_msg_source: hardware-to-software half of the Xsim portal message channel (FIFO + last-beat framing).
// The dpi_msgSource_beat call is presented on the dpi_* boundary; XSIM_SOURCE_STATS_EN adds msg/beat counters.
module xsim_msg_source #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] portal,
   output logic        RDY_beat,
   input  logic        EN_beat,
   input  logic [31:0] beat,
   output logic        msg_active,
   output logic        err_overflow,
`ifdef XSIM_SOURCE_STATS_EN
   output logic [31:0] msg_count,
   output logic [31:0] beat_count,
`endif
   output logic        dpi_call_c,
   output logic [31:0] dpi_portal_c,
   output logic [31:0] dpi_beat_c,
   output logic        dpi_last_c,
   input  logic [31:0] dpi_ret_i
);

   localparam int unsigned CW = AW + 1;

   typedef enum logic {HEADER = 1'b0, BODY = 1'b1} state_t;

   logic [31:0]   mem_q [DEPTH];
   logic [AW-1:0] rd_ptr_q, wr_ptr_q;
   logic [CW-1:0] count_q, count_d;
   state_t        state_q, state_d;
   logic [15:0]   remaining_q, remaining_d;
   logic          rdy_q, active_q, err_q;
   logic [31:0]   head;
   logic [15:0]   len;
   logic          enq, deq, last;

`ifdef XSIM_SOURCE_STATS_EN
   logic [31:0] msg_count_q, msg_count_d;
   logic [31:0] beat_count_q, beat_count_d;
`endif

   // Head decode, handshake qualification and framing next-state.
   always_comb begin
      head        = mem_q[rd_ptr_q];
      len         = head[15:0];
      enq         = EN_beat && rdy_q;
      deq         = !RST && (count_q != '0) && (dpi_ret_i != 32'd0);
      last        = (state_q == HEADER) ? (len <= 16'd1) : (remaining_q == 16'd1);
      count_d     = count_q;
      state_d     = state_q;
      remaining_d = remaining_q;
      if (enq && !deq) begin
         count_d = count_q + CW'(1);
      end else if (!enq && deq) begin
         count_d = count_q - CW'(1);
      end
      if (deq) begin
         if (state_q == HEADER) begin
            if (!last) begin
               remaining_d = len - 16'd1;
               state_d     = BODY;
            end
         end else begin
            remaining_d = remaining_q - 16'd1;
            if (remaining_q == 16'd1) begin
               state_d = HEADER;
            end
         end
      end
   end

`ifdef XSIM_SOURCE_STATS_EN
   always_comb begin
      beat_count_d = beat_count_q;
      msg_count_d  = msg_count_q;
      if (deq) begin
         beat_count_d = beat_count_q + 32'd1;
         if (last) begin
            msg_count_d = msg_count_q + 32'd1;
         end
      end
   end
`endif

   // Storage is not reset; valid entries are tracked by count_q.
   always_ff @(posedge CLK) begin
      if (!RST && enq) begin
         mem_q[wr_ptr_q] <= beat;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         count_q      <= '0;
         state_q      <= HEADER;
         remaining_q  <= 16'd0;
         rdy_q        <= 1'b1;
         active_q     <= 1'b0;
         err_q        <= 1'b0;
`ifdef XSIM_SOURCE_STATS_EN
         beat_count_q <= 32'd0;
         msg_count_q  <= 32'd0;
`endif
      end else begin
         if (enq) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (deq) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         count_q     <= count_d;
         state_q     <= state_d;
         remaining_q <= remaining_d;
         rdy_q       <= (count_d != CW'(DEPTH));
         active_q    <= (state_d == BODY);
         if (EN_beat && !rdy_q) begin
            err_q <= 1'b1;
         end
`ifdef XSIM_SOURCE_STATS_EN
         beat_count_q <= beat_count_d;
         msg_count_q  <= msg_count_d;
`endif
      end
   end

   assign RDY_beat     = rdy_q;
   assign msg_active   = active_q;
   assign err_overflow = err_q;
   assign dpi_call_c   = !RST && (count_q != '0);
   assign dpi_portal_c = portal;
   assign dpi_beat_c   = head;
   assign dpi_last_c   = last;
`ifdef XSIM_SOURCE_STATS_EN
   assign msg_count    = msg_count_q;
   assign beat_count   = beat_count_q;
`endif

endmodule

// File: tb/tb_xsim_msg_source.sv
// tb_xsim_msg_source: scenario tasks plus randomized run checked against a queue-based message model.
// The bench plays the simulator side of dpi_msgSource_beat by driving dpi_ret_i.
module tb_xsim_msg_source;

   localparam int unsigned DEPTH = 4;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [31:0] portal = 32'h0000_0007;
   logic        EN_beat = 1'b0;
   logic [31:0] beat = 32'd0;
   logic [31:0] dpi_ret_i = 32'd0;
   logic        RDY_beat, msg_active, err_overflow;
   logic        dpi_call_c, dpi_last_c;
   logic [31:0] dpi_portal_c, dpi_beat_c;
`ifdef XSIM_SOURCE_STATS_EN
   logic [31:0] msg_count, beat_count;
`endif

   xsim_msg_source #(.DEPTH(4), .AW(2)) dut (
      .CLK(CLK), .RST(RST), .portal(portal),
      .RDY_beat(RDY_beat), .EN_beat(EN_beat), .beat(beat),
      .msg_active(msg_active), .err_overflow(err_overflow),
`ifdef XSIM_SOURCE_STATS_EN
      .msg_count(msg_count), .beat_count(beat_count),
`endif
      .dpi_call_c(dpi_call_c), .dpi_portal_c(dpi_portal_c), .dpi_beat_c(dpi_beat_c),
      .dpi_last_c(dpi_last_c), .dpi_ret_i(dpi_ret_i)
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_fail = 0;

   // Reference model: buffered beats and beats still owed to the current message.
   logic [31:0] fifo_m[$];
   int unsigned msg_left;
   bit          ovf_m;
   int unsigned beats_m, msgs_m;

   logic [31:0] got_beat[$];
   logic        got_last[$];
   int          act_cycles;

   logic        obs_call, obs_last, obs_rdy, obs_act, obs_err;
   logic [31:0] obs_beat, obs_portal;
   logic        exp_call, exp_last, exp_rdy, exp_act, exp_err;
   logic [31:0] exp_beat;

   logic [31:0] seq3 [3] = '{32'h0005_0003, 32'hDEAD_BEEF, 32'h1234_5678};
   logic [31:0] bp5  [5] = '{32'h0000_0004, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003, 32'h0BAD_0BAD};
   logic        bpl  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

   function automatic bit model_last();
      int unsigned len;
      if (msg_left != 0) return msg_left == 1;
      len = 32'(fifo_m[0][15:0]);
      return len <= 1;
   endfunction

   // One clock: drive at negedge, sample, then advance the model across the posedge.
   task automatic step(input logic en, input logic [31:0] b, input logic [31:0] ret);
      bit enq, deq, lst;
      int unsigned len;
      @(negedge CLK);
      EN_beat = en; beat = b; dpi_ret_i = ret;
      #1;
      obs_call = dpi_call_c; obs_beat = dpi_beat_c; obs_last = dpi_last_c; obs_portal = dpi_portal_c;
      obs_rdy = RDY_beat; obs_act = msg_active; obs_err = err_overflow;
      exp_call = fifo_m.size() != 0;
      exp_beat = exp_call ? fifo_m[0] : 32'd0;
      exp_last = exp_call ? model_last() : 1'b0;
      exp_rdy  = fifo_m.size() < DEPTH;
      exp_act  = msg_left != 0;
      exp_err  = ovf_m;
      if (obs_act === 1'b1) act_cycles++;
      if (obs_call === 1'b1 && ret != 0) begin
         got_beat.push_back(obs_beat);
         got_last.push_back(obs_last);
      end
      @(posedge CLK);
      enq = en && exp_rdy;
      deq = exp_call && (ret != 0);
      if (en && !exp_rdy) ovf_m = 1'b1;
      if (deq) begin
         lst = model_last();
         beats_m++;
         if (lst) msgs_m++;
         if (msg_left == 0) begin
            len = 32'(fifo_m[0][15:0]);
            msg_left = (len <= 1) ? 0 : len - 1;
         end else begin
            msg_left--;
         end
         void'(fifo_m.pop_front());
      end
      if (enq) fifo_m.push_back(b);
      #1;
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b1; EN_beat = 1'b0; dpi_ret_i = 32'd1;
      @(negedge CLK);
      RST = 1'b0;
      fifo_m.delete(); msg_left = 0; ovf_m = 1'b0; beats_m = 0; msgs_m = 0;
      got_beat.delete(); got_last.delete(); act_cycles = 0;
   endtask

   task automatic test_reset();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 32'd0, 32'd1);
         n_cmp++;
         if ({obs_rdy, obs_act, obs_err, obs_call} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_idle cyc=%0d got rdy/act/err/call=%b%b%b%b want 1000", i, obs_rdy, obs_act, obs_err, obs_call);
         end
      end
   endtask

   task automatic test_basic_msg();
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, seq3[i], 32'd1);
      for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 32'd1);
      n_cmp++;
      if (got_beat.size() != 3) begin
         n_fail++;
         $display("FAIL basic_count got %0d beats want 3", got_beat.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (got_beat[i] !== seq3[i] || got_last[i] !== (i == 2)) begin
               n_fail++;
               $display("FAIL basic_beat%0d got %h/last=%b want %h/last=%b", i, got_beat[i], got_last[i], seq3[i], (i == 2));
            end
         end
      end
      n_cmp++;
      if (act_cycles != 2 || obs_act !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_active got %0d cycles (final %b) want 2 (final 0)", act_cycles, obs_act);
      end
      n_cmp++;
      if (obs_portal !== portal) begin
         n_fail++;
         $display("FAIL basic_portal got %h want %h", obs_portal, portal);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         step(1'b1, bp5[i], 32'd0);
         n_cmp++;
         if (obs_rdy !== (i < 4)) begin
            n_fail++;
            $display("FAIL bp_rdy enq%0d got %b want %b", i, obs_rdy, (i < 4));
         end
      end
      step(1'b0, 32'd0, 32'd0);
      n_cmp++;
      if (obs_err !== 1'b1 || obs_rdy !== 1'b0 || obs_call !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_overflow got err/rdy/call=%b%b%b want 101", obs_err, obs_rdy, obs_call);
      end
      for (int i = 0; i < 8; i++) step(1'b0, 32'd0, 32'd1);
      n_cmp++;
      if (got_beat.size() != 4) begin
         n_fail++;
         $display("FAIL bp_count got %0d beats want 4", got_beat.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (got_beat[i] !== bp5[i] || got_last[i] !== bpl[i]) begin
               n_fail++;
               $display("FAIL bp_beat%0d got %h/%b want %h/%b", i, got_beat[i], got_last[i], bp5[i], bpl[i]);
            end
         end
      end
      n_cmp++;
      if (obs_err !== 1'b1 || obs_rdy !== 1'b1 || obs_act !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_after got err/rdy/act=%b%b%b want 110", obs_err, obs_rdy, obs_act);
      end
   endtask

   task automatic test_len0();
      do_reset();
      step(1'b1, 32'h0001_0000, 32'd1);
      step(1'b1, 32'h0002_0001, 32'd1);
      for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 32'd1);
      n_cmp++;
      if (got_beat.size() != 2 || act_cycles != 0) begin
         n_fail++;
         $display("FAIL len0_count got %0d calls, %0d active cycles want 2, 0", got_beat.size(), act_cycles);
      end else begin
         n_cmp++;
         if (got_beat[0] !== 32'h0001_0000 || got_beat[1] !== 32'h0002_0001 || got_last[0] !== 1'b1 || got_last[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL len0_beats got %h/%b %h/%b want 00010000/1 00020001/1", got_beat[0], got_last[0], got_beat[1], got_last[1]);
         end
      end
   endtask

   task automatic test_midreset();
      do_reset();
      step(1'b1, 32'h0000_0004, 32'd0);
      step(1'b1, 32'hB000_0001, 32'd0);
      step(1'b1, 32'hB000_0002, 32'd0);
      step(1'b1, 32'hB000_0003, 32'd0);
      step(1'b0, 32'd0, 32'd1);
      step(1'b0, 32'd0, 32'd1);
      n_cmp++;
      if (got_beat.size() != 2 || obs_act !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_pre got %0d beats act=%b want 2 act=1", got_beat.size(), obs_act);
      end
      @(negedge CLK);
      RST = 1'b1; EN_beat = 1'b0; dpi_ret_i = 32'd1;
      #1;
      n_cmp++;
      if (dpi_call_c !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_call_in_reset got %b want 0", dpi_call_c);
      end
      @(negedge CLK);
      RST = 1'b0;
      fifo_m.delete(); msg_left = 0; ovf_m = 1'b0;
      got_beat.delete(); got_last.delete(); act_cycles = 0;
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 32'd0, 32'd1);
         n_cmp++;
         if ({obs_call, obs_rdy, obs_act} !== 3'b010) begin
            n_fail++;
            $display("FAIL midrst_after cyc=%0d got call/rdy/act=%b%b%b want 010", i, obs_call, obs_rdy, obs_act);
         end
      end
      step(1'b1, 32'h0000_0002, 32'd1);
      step(1'b1, 32'hCAFE_F00D, 32'd1);
      for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 32'd1);
      n_cmp++;
      if (got_beat.size() != 2 || got_beat[0] !== 32'h0000_0002 || got_beat[1] !== 32'hCAFE_F00D
          || got_last[0] !== 1'b0 || got_last[1] !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_new got %0d beats (first %h) want 00000002/0 cafef00d/1", got_beat.size(),
                  (got_beat.size() > 0) ? got_beat[0] : 32'hx);
      end
   endtask

   task automatic test_random();
      logic [31:0] b;
      logic        en;
      logic [31:0] ret;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         en  = ($urandom_range(0, 99) < 60);
         b   = $urandom;
         if ($urandom_range(0, 1) == 0) b[15:0] = 16'($urandom_range(0, 4));
         ret = ($urandom_range(0, 99) < 55) ? 32'($urandom_range(1, 1000)) : 32'd0;
         step(en, b, ret);
         n_cmp++;
         if (obs_call !== exp_call || (exp_call && (obs_beat !== exp_beat || obs_last !== exp_last))
             || obs_rdy !== exp_rdy || obs_act !== exp_act || obs_err !== exp_err) begin
            n_fail++;
            $display("FAIL random cyc=%0d got call=%b beat=%h last=%b rdy=%b act=%b err=%b want call=%b beat=%h last=%b rdy=%b act=%b err=%b",
                     i, obs_call, obs_beat, obs_last, obs_rdy, obs_act, obs_err,
                     exp_call, exp_beat, exp_last, exp_rdy, exp_act, exp_err);
         end
`ifdef XSIM_SOURCE_STATS_EN
         n_cmp++;
         if (beat_count !== 32'(beats_m) || msg_count !== 32'(msgs_m)) begin
            n_fail++;
            $display("FAIL random_stats cyc=%0d got beats=%0d msgs=%0d want %0d %0d", i, beat_count, msg_count, beats_m, msgs_m);
         end
`endif
      end
   endtask

`ifdef XSIM_SOURCE_STATS_EN
   task automatic test_stats();
      do_reset();
      step(1'b1, 32'h0000_0001, 32'd1);
      step(1'b1, 32'h0000_0003, 32'd1);
      step(1'b1, 32'h1111_1111, 32'd1);
      step(1'b1, 32'h2222_2222, 32'd1);
      step(1'b1, 32'h0000_0002, 32'd1);
      step(1'b1, 32'h3333_3333, 32'd1);
      for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 32'd1);
      n_cmp++;
      if (beat_count !== 32'd6 || msg_count !== 32'd3) begin
         n_fail++;
         $display("FAIL stats_counts got beats=%0d msgs=%0d want 6 3", beat_count, msg_count);
      end
      @(negedge CLK);
      force dut.beat_count_q = 32'hFFFF_FFFF;
      #1;
      release dut.beat_count_q;
      step(1'b1, 32'h0000_0001, 32'd1);
      step(1'b0, 32'd0, 32'd1);
      n_cmp++;
      if (beat_count !== 32'd0 || msg_count !== 32'd4) begin
         n_fail++;
         $display("FAIL stats_wrap got beats=%h msgs=%0d want 00000000 4", beat_count, msg_count);
      end
   endtask
`endif

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic_msg();
      test_backpressure();
      test_len0();
      test_midreset();
      test_random();
`ifdef XSIM_SOURCE_STATS_EN
      test_stats();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
